// File: rtl/writeback_regfile_if.sv
// Write-back stage bus: the incoming beat, the decode reservation port, the read ports and the
// retirement/status outputs of writeback_regfile.
interface writeback_regfile_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned RIP_W  = 32,
  parameter int unsigned NRD    = 2
);
  localparam int unsigned REG_W = $clog2(NREGS);

  logic                    wb_valid;
  logic                    wb_ready;
  logic [RIP_W-1:0]        wb_rip;
  logic [REG_W-1:0]        wb_dest;
  logic                    wb_dest_valid;
  logic [DATA_W-1:0]       wb_result;
  logic [REG_W-1:0]        wb_dest2;
  logic                    wb_dest2_valid;
  logic [DATA_W-1:0]       wb_result2;
  logic                    wb_kill;
  logic                    rsv_valid;
  logic [REG_W-1:0]        rsv_reg;
  logic [NRD*REG_W-1:0]    rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NREGS-1:0]        busy_map;
  logic                    retire_valid;
  logic [RIP_W-1:0]        retire_rip;
  logic [31:0]             retire_count;
  logic                    halted;

  // Upstream side: ALU/memory stage, decode and register readers.
  modport master (
    output wb_valid, wb_rip, wb_dest, wb_dest_valid, wb_result,
    output wb_dest2, wb_dest2_valid, wb_result2, wb_kill,
    output rsv_valid, rsv_reg, rd_addr,
    input  wb_ready, rd_data, busy_map, retire_valid, retire_rip, retire_count, halted
  );

  // Write-back stage side.
  modport slave (
    input  wb_valid, wb_rip, wb_dest, wb_dest_valid, wb_result,
    input  wb_dest2, wb_dest2_valid, wb_result2, wb_kill,
    input  rsv_valid, rsv_reg, rd_addr,
    output wb_ready, rd_data, busy_map, retire_valid, retire_rip, retire_count, halted
  );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage: owns the architectural register file and the busy scoreboard, retires one
// beat per cycle and halts after a kill beat. Define WB_BYPASS_EN to forward the beat being
// accepted this cycle onto the read ports.
module writeback_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned RIP_W  = 32,
  parameter int unsigned NRD    = 2
) (
  input logic            clk,
  input logic            reset,
  writeback_regfile_if.slave wb_io
);
  localparam int unsigned REG_W = $clog2(NREGS);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic                ready, halted;
  logic                accept, wb_write, rsv_set;
  logic [DATA_W-1:0]   rf_q [NREGS];
  logic [DATA_W-1:0]   rf_d [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic                retire_valid_q, retire_valid_d;
  logic [RIP_W-1:0]    retire_rip_q, retire_rip_d;
  logic [31:0]         retire_count_q, retire_count_d;
  logic [REG_W-1:0]    rd_idx;
  logic [NRD*DATA_W-1:0] rd_data;

  // Reset discards any beat or reservation presented in the same cycle.
  assign accept   = wb_io.wb_valid & ready & ~reset;
  assign wb_write = accept & ~wb_io.wb_kill;
  assign rsv_set  = wb_io.rsv_valid & (state_q == StRun) & ~reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  // Next state: an accepted kill beat halts until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (accept && wb_io.wb_kill) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // FSM outputs; ready is forced high while reset is asserted.
  always_comb begin
    ready  = reset | (state_q == StRun);
    halted = (state_q == StHalted);
  end

  // Register file and scoreboard next state; primary write and reservation set are applied last.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wb_write) begin
      if (wb_io.wb_dest2_valid) begin
        rf_d[wb_io.wb_dest2]   = wb_io.wb_result2;
        busy_d[wb_io.wb_dest2] = 1'b0;
      end
      if (wb_io.wb_dest_valid) begin
        rf_d[wb_io.wb_dest]   = wb_io.wb_result;
        busy_d[wb_io.wb_dest] = 1'b0;
      end
    end
    if (rsv_set) busy_d[wb_io.rsv_reg] = 1'b1;
  end

  // Register file and scoreboard storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  // Retirement next state: pulse per accepted beat, rip held between pulses.
  always_comb begin
    retire_valid_d = accept;
    retire_rip_d   = accept ? wb_io.wb_rip : retire_rip_q;
    retire_count_d = retire_count_q + 32'(accept);
  end

  // Retirement registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_valid_q <= 1'b0;
      retire_rip_q   <= '0;
      retire_count_q <= '0;
    end else begin
      retire_valid_q <= retire_valid_d;
      retire_rip_q   <= retire_rip_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Combinational read ports, optionally forwarding the beat being written this cycle.
  always_comb begin
    rd_data = '0;
    rd_idx  = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_idx = wb_io.rd_addr[i*REG_W +: REG_W];
      rd_data[i*DATA_W +: DATA_W] = rf_q[rd_idx];
`ifdef WB_BYPASS_EN
      if (wb_write && wb_io.wb_dest2_valid && (rd_idx == wb_io.wb_dest2)) begin
        rd_data[i*DATA_W +: DATA_W] = wb_io.wb_result2;
      end
      if (wb_write && wb_io.wb_dest_valid && (rd_idx == wb_io.wb_dest)) begin
        rd_data[i*DATA_W +: DATA_W] = wb_io.wb_result;
      end
`else
      rd_data[i*DATA_W +: DATA_W] = rf_q[rd_idx];
`endif
    end
  end

  assign wb_io.wb_ready     = ready;
  assign wb_io.halted       = halted;
  assign wb_io.rd_data      = rd_data;
  assign wb_io.busy_map     = busy_q;
  assign wb_io.retire_valid = retire_valid_q;
  assign wb_io.retire_rip   = retire_rip_q;
  assign wb_io.retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: a driver issues directed and random beats against an
// array-based reference model; a monitor pops expected retirements whenever retire_valid pulses.
module tb_writeback_regfile;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned RIP_W  = 32;
  localparam int unsigned NRD    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_regfile_if #(.DATA_W(DATA_W), .NREGS(NREGS), .RIP_W(RIP_W), .NRD(NRD)) bus ();

  writeback_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RIP_W(RIP_W), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .wb_io (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rip;
    logic [31:0] count;
    bit          halted;
  } ret_t;

  ret_t        rq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // Reference model state.
  logic [63:0] m_rf [16];
  logic [15:0] m_busy;
  bit          m_halted;
  logic [31:0] m_count;
  logic [31:0] m_rip;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_busy   = '0;
    m_halted = 1'b0;
    m_count  = '0;
    m_rip    = '0;
  endtask

  // One cycle: drive inputs after the falling edge, check visible state, then advance the model.
  task automatic drive(input bit rst, input bit v, input logic [31:0] rip,
                       input logic [3:0] d, input bit dv, input logic [63:0] r,
                       input logic [3:0] d2, input bit d2v, input logic [63:0] r2,
                       input bit kill, input bit rsv, input logic [3:0] rr,
                       input logic [7:0] addrs);
    bit acc;
    logic [3:0] a;
    logic [63:0] exp;
    @(negedge clk);
    reset              = rst;
    bus.wb_valid       = v;
    bus.wb_rip         = rip;
    bus.wb_dest        = d;
    bus.wb_dest_valid  = dv;
    bus.wb_result      = r;
    bus.wb_dest2       = d2;
    bus.wb_dest2_valid = d2v;
    bus.wb_result2     = r2;
    bus.wb_kill        = kill;
    bus.rsv_valid      = rsv;
    bus.rsv_reg        = rr;
    bus.rd_addr        = addrs;
    #1;
    acc = v && !m_halted && !rst;
    check("wb_ready", {63'd0, bus.wb_ready}, {63'd0, rst || !m_halted});
    check("halted", {63'd0, bus.halted}, {63'd0, m_halted});
    check("busy_map", {48'd0, bus.busy_map}, {48'd0, m_busy});
    check("retire_count", {32'd0, bus.retire_count}, {32'd0, m_count});
    check("retire_rip", {32'd0, bus.retire_rip}, {32'd0, m_rip});
    for (int p = 0; p < 2; p++) begin
      a = addrs[p*4 +: 4];
      exp = m_rf[a];
`ifdef WB_BYPASS_EN
      if (acc && !kill && d2v && a == d2) exp = r2;
      if (acc && !kill && dv && a == d) exp = r;
`endif
      check($sformatf("rd_data[%0d] addr %0d", p, a), bus.rd_data[p*64 +: 64], exp);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (acc && !kill) begin
        if (d2v) begin m_rf[d2] = r2; m_busy[d2] = 1'b0; end
        if (dv)  begin m_rf[d]  = r;  m_busy[d]  = 1'b0; end
      end
      if (rsv && !m_halted) m_busy[rr] = 1'b1;
      if (acc) begin
        m_count = m_count + 1;
        m_rip   = rip;
        if (kill) m_halted = 1'b1;
        rq.push_back('{cyc: cyc + 1, rip: rip, count: m_count, halted: kill});
      end
    end
  endtask

  task automatic idle(input logic [7:0] addrs);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, addrs);
  endtask

  task automatic drive_rand(input bit rst, input int kill_pct);
    drive(rst, $urandom_range(0, 99) < 75, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom),
          {$urandom, $urandom}, $urandom_range(0, 99) < kill_pct,
          $urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)), 8'($urandom));
  endtask

  // Monitor: every retire pulse must match the oldest expected retirement, on time.
  always @(negedge clk) begin
    ret_t e;
    if (bus.retire_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL retire_spurious: got pulse rip %0h expected none", bus.retire_rip);
      end else begin
        e = rq.pop_front();
        check("retire_cycle", 64'(cyc), 64'(e.cyc));
        check("retire_pulse_rip", {32'd0, bus.retire_rip}, {32'd0, e.rip});
        check("retire_pulse_count", {32'd0, bus.retire_count}, {32'd0, e.count});
        check("retire_pulse_halted", {63'd0, bus.halted}, {63'd0, e.halted});
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      checks++;
      failures++;
      $display("FAIL retire_missing: got no pulse expected rip %0h", rq[0].rip);
      void'(rq.pop_front());
    end
  end

  initial begin
    model_reset();
    reset = 1'b1;
    // Reset with a valid beat and reservation present: both must be discarded.
    drive(1, 1, 32'h40, 4'd2, 1, 64'h77, 4'd3, 1, 64'h88, 0, 1, 4'd2, 8'h32);
    drive(1, 1, 32'h44, 4'd2, 1, 64'h77, 4'd3, 1, 64'h88, 0, 1, 4'd2, 8'h32);
    idle(8'h32);
    idle(8'h32);

    // Basic beat, then read it back.
    drive(0, 1, 32'h100, 4'd3, 1, 64'hDEAD, 4'd0, 0, 0, 0, 0, 0, 8'h33);
    idle(8'h33);
    idle(8'h33);

    // Reserve r5, clear it two cycles later.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 8'h05);
    idle(8'h05);
    drive(0, 1, 32'h104, 4'd5, 1, 64'h1234, 4'd0, 0, 0, 0, 0, 0, 8'h05);
    idle(8'h05);
    // Reserve again, then clear and re-reserve in the same cycle: set wins.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 8'h05);
    drive(0, 1, 32'h108, 4'd5, 1, 64'h5678, 4'd0, 0, 0, 0, 1, 4'd5, 8'h05);
    idle(8'h05);

    // Same primary and secondary destination: primary wins.
    drive(0, 1, 32'h10C, 4'd7, 1, 64'h11, 4'd7, 1, 64'h22, 0, 0, 0, 8'h77);
    idle(8'h77);

    // Same-cycle read of a register being written.
    drive(0, 1, 32'h110, 4'd4, 1, 64'h55, 4'd9, 1, 64'h99, 0, 0, 0, 8'h94);
    idle(8'h94);

    // Random traffic with occasional kills and resets.
    for (int i = 0; i < 3000; i++) begin
      if (m_halted) drive_rand($urandom_range(0, 19) == 0, 2);
      else          drive_rand($urandom_range(0, 399) == 0, 1);
    end
    drive_rand(1, 0);
    idle(8'h10);

    // Counter wrap: preload the counter, then retire one beat.
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    m_count = 32'hFFFF_FFFF;
    drive(0, 1, 32'h180, 4'd6, 1, 64'hABC, 4'd0, 0, 0, 0, 0, 0, 8'h16);
    idle(8'h16);

    // Kill beat, then keep offering beats and reservations while halted.
    drive(0, 1, 32'h200, 4'd1, 1, 64'hBAD, 4'd0, 0, 0, 1, 0, 0, 8'h11);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h204, 4'd1, 1, 64'hF00D, 4'd2, 1, 64'hF00E, 0, 1, 4'd8, 8'h21);
    end
    idle(8'h81);
    idle(8'h81);

    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL retire_drain: got %0d pending expected 0", rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Parametrised write-back stage that owns the architectural register file and the register in-use scoreboard. It sits after the ALU/memory stage and before retirement. Each accepted beat writes a primary and an optional secondary destination, clears their busy bits, and retires the instruction. Decode reserves destinations through a separate port, and a kill beat halts the core cleanly instead of stopping simulation.

## Interface
- DATA_W, 64, register width
- NREGS, 16, number of architectural registers (power of two)
- REG_W, $clog2(NREGS), register index width (derived, not overridden)
- RIP_W, 32, instruction pointer width
- NRD, 2, number of read ports
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  write-back beat valid
- wb_ready  out  1  stage accepts a beat; a beat transfers when wb_valid & wb_ready
- wb_rip  in  RIP_W  instruction pointer of the beat
- wb_dest  in  REG_W  primary destination
- wb_dest_valid  in  1  primary destination present
- wb_result  in  DATA_W  primary result
- wb_dest2  in  REG_W  secondary ("special") destination
- wb_dest2_valid  in  1  secondary destination present
- wb_result2  in  DATA_W  secondary result
- wb_kill  in  1  beat is the terminating instruction
- rsv_valid  in  1  decode reserves a register
- rsv_reg  in  REG_W  register to mark busy
- rd_addr  in  NRD*REG_W  read addresses, port i at bits [i*REG_W +: REG_W]
- rd_data  out  NRD*DATA_W  read data, same packing
- busy_map  out  NREGS  scoreboard, bit r = register r in use
- retire_valid  out  1  one-cycle pulse per retired beat
- retire_rip  out  RIP_W  instruction pointer of the retired beat
- retire_count  out  32  retired-beat counter, kill beat included
- halted  out  1  core halted after a kill

## Operation
- States: RUN and HALTED. Reset enters RUN.
- wb_ready = (state == RUN). It does not depend on wb_valid.
- Accepted beat with wb_kill = 0:
  - if wb_dest2_valid: regfile[wb_dest2] <= wb_result2 and busy[wb_dest2] <= 0
  - if wb_dest_valid: regfile[wb_dest] <= wb_result and busy[wb_dest] <= 0
  - if wb_dest == wb_dest2 and both are valid, the primary destination wins.
- Accepted beat with wb_kill = 1: no register or busy update. The beat still retires, and the state moves to HALTED.
- Reservation: when rsv_valid is high in RUN, busy[rsv_reg] <= 1. If a write-back clears the same register in the same cycle, the set wins, because a younger writer holds the register.
- In HALTED: rsv_valid and wb_valid are ignored. Registers, busy_map and the counter are frozen. Only reset leaves HALTED.
- rd_data reads regfile combinationally.
- retire_count increments by 1 per accepted beat and wraps from 2^32-1 to 0.
- Reset values: every regfile entry 0, busy_map 0, retire_valid 0, retire_rip 0, retire_count 0, halted 0, state RUN. wb_ready reads 1 during reset.
- Reset mid-operation takes priority over any accepted beat or reservation in the same cycle. That beat is discarded and not counted.

## Timing
- Register writes and busy updates are visible on rd_data and busy_map in the cycle after acceptance. Latency is 1.
- retire_valid and retire_rip are registered. They pulse in the cycle after acceptance. retire_count updates in the same cycle as the pulse.
- halted rises in the cycle after the kill beat is accepted, coincident with that beat's retire_valid. wb_ready falls in the same cycle.
- Back-to-back beats are accepted every cycle in RUN. Throughput is 1 beat per cycle.

## Configuration
- WB_BYPASS_EN defined:
  - a read port whose address matches a valid destination of the beat being accepted this cycle returns the incoming result combinationally
  - the primary destination takes priority over the secondary
  - kill beats never forward
- WB_BYPASS_EN undefined: rd_data returns only the stored register value. A same-cycle read returns the old value.

## Test plan
- Reset, then accept a beat with dest=3, result=0xDEAD, rip=0x100 -> next cycle: rd_data (addr 3) = 0xDEAD, retire_valid=1, retire_rip=0x100, retire_count=1.
- rsv_reg=5 in cycle 0, write-back of dest=5 in cycle 2 -> busy_map[5] is 1 in cycles 1-2 and 0 from cycle 3. A simultaneous rsv_reg=5 in cycle 2 leaves busy_map[5]=1.
- Beat with dest=dest2=7, result=0x11, result2=0x22 -> regfile[7]=0x11.
- Kill beat at rip=0x200, then wb_valid held high with dest=1 -> one retire pulse with rip 0x200, halted=1, wb_ready=0, regfile[1] unchanged, retire_count does not advance further.
- Read addr 4 in the same cycle a beat writes 0x55 to reg 4 -> 0x55 with WB_BYPASS_EN, old value without it.
- Preload retire_count to 0xFFFFFFFF by forcing or by a long run, then accept one beat -> count = 0. Assert reset together with a valid beat -> all outputs return to reset values and the beat is not written.
